ir_packet_tx: RTL

- Consumes the 36 kHz carrier from the IR clock generator and gates it into the IR LED drive as one remote-control packet per request.
- Packet: start burst, car-select burst, then four command-bit bursts (right, left, backward, forward). Every burst is followed by a fixed gap.
- All lengths are counted in carrier periods.
- Sits between the command/bus interface (SEND, COMMAND) and the IR LED pin.

---
 rtl/ir_pkg.sv | 41 ++++
 rtl/ir_period_counter.sv | 36 +++
 rtl/ir_packet_tx.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ir_pkg.sv
// Shared types and default burst lengths for the IR remote-control packet transmitters.
package ir_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      BURST = 2'd2,
      GAP   = 2'd3
   } ir_state_t;

   typedef logic [2:0] seg_t;

   localparam seg_t LAST_SEG = 3'd5;

   localparam int DEF_START_LEN = 191;
   localparam int DEF_CAR_LEN   = 47;
   localparam int DEF_ONE_LEN   = 47;
   localparam int DEF_ZERO_LEN  = 22;
   localparam int DEF_GAP_LEN   = 25;
   localparam int DEF_CNT_W     = 8;

   // seg 0 = start, seg 1 = car select, seg 2..5 = command bits 3..0
   function automatic int seg_len(input seg_t       seg,
                                  input logic [3:0] cmd,
                                  input int         start_len,
                                  input int         car_len,
                                  input int         one_len,
                                  input int         zero_len);
      logic bit_v;
      case (seg)
         3'd2:    bit_v = cmd[3];
         3'd3:    bit_v = cmd[2];
         3'd4:    bit_v = cmd[1];
         default: bit_v = cmd[0];
      endcase
      if (seg == 3'd0) return start_len;
      if (seg == 3'd1) return car_len;
      return bit_v ? one_len : zero_len;
   endfunction

endpackage

// File: rtl/ir_period_counter.sv
// Carrier rising-edge detector plus a carrier-period counter with terminal compare.
module ir_period_counter #(
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_carrier,
   input  logic             i_load,
   input  logic             i_inc,
   input  logic [CNT_W-1:0] i_len,
   output logic             o_rise,
   output logic             o_term,
   output logic             o_carrier_q
);

   logic             r_carrier_d;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_carrier_d <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_carrier_d <= i_carrier;
         if (i_load)
            r_cnt <= CNT_W'(1);
         else if (i_inc)
            r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_rise      = i_carrier & ~r_carrier_d;
   assign o_term      = (r_cnt == i_len);
   assign o_carrier_q = r_carrier_d;

endmodule

// File: rtl/ir_packet_tx.sv
// Gates the carrier into the IR LED as one packet per SEND: start, car select,
// four command bits, each burst followed by a fixed dark gap.
//
//   state | meaning
//   IDLE  | waiting for SEND
//   ARM   | packet accepted, waiting for the first carrier rise
//   BURST | LED follows carrier for the current segment length
//   GAP   | LED dark for GAP_LEN periods, then next segment or done
module ir_packet_tx
   import ir_pkg::*;
#(
   parameter int START_LEN = DEF_START_LEN,
   parameter int CAR_LEN   = DEF_CAR_LEN,
   parameter int ONE_LEN   = DEF_ONE_LEN,
   parameter int ZERO_LEN  = DEF_ZERO_LEN,
   parameter int GAP_LEN   = DEF_GAP_LEN,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic       CLK,
   input  logic       RESETN,
   input  logic       CARRIER,
   input  logic       SEND,
   input  logic [3:0] COMMAND,
   output logic       IR_LED,
   output logic       BUSY,
   output logic       DONE
);

   ir_state_t  r_state;
   seg_t       r_seg;
   logic [3:0] r_cmd_q;
   logic       r_busy;
   logic       r_done;
   logic       r_burst_en;

   ir_state_t  w_state_nxt;
   seg_t       w_seg_nxt;
   logic [3:0] w_cmd_nxt;
   logic       w_load;
   logic       w_inc;
   logic       w_done_nxt;

   logic             w_rise;
   logic             w_term;
   logic             w_carrier_q;
   logic [CNT_W-1:0] w_burst_len;
   logic [CNT_W-1:0] w_len;

   assign w_burst_len = CNT_W'(seg_len(r_seg, r_cmd_q, START_LEN, CAR_LEN, ONE_LEN, ZERO_LEN));
   assign w_len       = (r_state == GAP) ? CNT_W'(GAP_LEN) : w_burst_len;

   ir_period_counter #(
      .CNT_W (CNT_W)
   ) u_period_counter (
      .i_clk       (CLK),
      .i_rst_n     (RESETN),
      .i_carrier   (CARRIER),
      .i_load      (w_load),
      .i_inc       (w_inc),
      .i_len       (w_len),
      .o_rise      (w_rise),
      .o_term      (w_term),
      .o_carrier_q (w_carrier_q)
   );

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         r_state    <= IDLE;
         r_seg      <= '0;
         r_cmd_q    <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_burst_en <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_seg      <= w_seg_nxt;
         r_cmd_q    <= w_cmd_nxt;
         r_busy     <= (w_state_nxt != IDLE);
         r_done     <= w_done_nxt;
         r_burst_en <= (w_state_nxt == BURST);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_seg_nxt   = r_seg;
      w_cmd_nxt   = r_cmd_q;
      w_load      = 1'b0;
      w_inc       = 1'b0;
      w_done_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            if (SEND) begin
               w_cmd_nxt   = COMMAND;
               w_seg_nxt   = '0;
               w_state_nxt = ARM;
            end
         end
         ARM: begin
            if (w_rise) begin
               w_state_nxt = BURST;
               w_load      = 1'b1;
            end
         end
         BURST: begin
            if (w_rise) begin
               if (w_term) begin
                  w_state_nxt = GAP;
                  w_load      = 1'b1;
               end else begin
                  w_inc = 1'b1;
               end
            end
         end
         GAP: begin
            if (w_rise) begin
               if (!w_term) begin
                  w_inc = 1'b1;
               end else if (r_seg < LAST_SEG) begin
                  w_seg_nxt   = r_seg + 3'd1;
                  w_state_nxt = BURST;
                  w_load      = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
                  w_done_nxt  = 1'b1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Registered carrier AND registered enable: no logic glitches reach the pin
   assign IR_LED = w_carrier_q & r_burst_en;
   assign BUSY   = r_busy;
   assign DONE   = r_done;

endmodule
